// File: rtl/sequential_array_multiplier_pkg.sv
// sequential_array_multiplier_pkg: shared FSM state type and sizing helpers
// for the iterative multiplier (iteration count, counter width, pow2 test).
package sequential_array_multiplier_pkg;

    typedef enum logic [1:0] {
        IDLE,
        MULTIPLY,
        DONE
    } mul_state_t;

    function automatic int calc_iter(input int width, input int per_stage);
        return width / per_stage;
    endfunction

    // A single-iteration configuration still needs a one-bit counter.
    function automatic int calc_cnt_w(input int iter);
        return (iter > 1) ? $clog2(iter) : 1;
    endfunction

    function automatic bit is_pow2(input int v);
        return (v > 0) && ((v & (v - 1)) == 0);
    endfunction

endpackage

// File: rtl/pipelined_array_multiplier_stage.sv
// pipelined_array_multiplier_stage: one slice of an array multiplier.
// Ports: A, P bits of B, fed-back partial/carry in; new partial/carry and P result bits out.
module pipelined_array_multiplier_stage #(
    parameter int DATA_WIDTH        = 8,
    parameter int PRODUCT_PER_STAGE = 4
) (
    input  logic [DATA_WIDTH-1:0]        operand_A_i,
    input  logic [PRODUCT_PER_STAGE-1:0] operand_B_i,
    input  logic [DATA_WIDTH-2:0]        last_partial_prod_i,
    input  logic                         carry_i,
    output logic [DATA_WIDTH-2:0]        partial_prod_o,
    output logic                         carry_o,
    output logic [PRODUCT_PER_STAGE-1:0] final_result_bits_o
);

    localparam int W = DATA_WIDTH;
    localparam int P = PRODUCT_PER_STAGE;

    // {carry, partial} is the running upper W bits of the product. Each
    // row adds A gated by one B bit, retires the LSB as a result bit and
    // shifts the remaining sum down for the next row.
    logic [W-1:0] acc;
    logic [W:0]   row_sum;
    logic [P-1:0] bits;

    always_comb begin
        acc     = {carry_i, last_partial_prod_i};
        row_sum = '0;
        bits    = '0;
        for (int j = 0; j < P; j++) begin
            row_sum = {1'b0, acc}
                    + {1'b0, operand_A_i & {W{operand_B_i[j]}}};
            bits[j] = row_sum[0];
            acc     = row_sum[W:1];
        end
    end

    assign partial_prod_o      = acc[W-2:0];
    assign carry_o             = acc[W-1];
    assign final_result_bits_o = bits;

endmodule

// File: rtl/sequential_array_multiplier.sv
// sequential_array_multiplier: iterative unsigned A*B reusing one array stage.
// Ports: clk_i, rst_i (sync high), operand_A_i/B_i + valid_i/ready_o in; result_o + valid_o/ready_i out.
module sequential_array_multiplier
    import sequential_array_multiplier_pkg::*;
#(
    parameter int DATA_WIDTH        = 8,
    parameter int PRODUCT_PER_STAGE = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [DATA_WIDTH-1:0]   operand_A_i,
    input  logic [DATA_WIDTH-1:0]   operand_B_i,
    input  logic                    valid_i,
    output logic                    ready_o,
    output logic [2*DATA_WIDTH-1:0] result_o,
    output logic                    valid_o,
    input  logic                    ready_i
);

    localparam int W     = DATA_WIDTH;
    localparam int P     = PRODUCT_PER_STAGE;
    localparam int ITER  = calc_iter(W, P);
    localparam int CNT_W = calc_cnt_w(ITER);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(ITER - 1);

    if (!is_pow2(W) || (W < 4)) begin : g_bad_width
        $error("DATA_WIDTH must be a power of 2 and at least 4");
    end

    if (!is_pow2(P) || (P >= W) || ((W % P) != 0)) begin : g_bad_slice
        $error("PRODUCT_PER_STAGE must be a power of 2 below DATA_WIDTH");
    end

    mul_state_t     state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [W-1:0]   a_q;
    logic [W-1:0]   b_q;
    logic [W-2:0]   partial_q;
    logic           carry_q;
    logic [W-1:0]   low_q;
    logic [2*W-1:0] result_q;
    logic           valid_q;
    logic           ready_q;

    logic [W-2:0]   stage_partial;
    logic           stage_carry;
    logic [P-1:0]   stage_bits;
    logic [W-1:0]   low_next;

    pipelined_array_multiplier_stage #(
        .DATA_WIDTH        (W),
        .PRODUCT_PER_STAGE (P)
    ) u_stage (
        .operand_A_i         (a_q),
        .operand_B_i         (b_q[P-1:0]),
        .last_partial_prod_i (partial_q),
        .carry_i             (carry_q),
        .partial_prod_o      (stage_partial),
        .carry_o             (stage_carry),
        .final_result_bits_o (stage_bits)
    );

    // New result bits enter at the top; after ITER shifts the
    // register holds the low half of the product.
    assign low_next = {stage_bits, low_q[W-1:P]};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            partial_q <= '0;
            carry_q   <= 1'b0;
            low_q     <= '0;
            result_q  <= '0;
            valid_q   <= 1'b0;
            ready_q   <= 1'b1;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (valid_i && ready_q) begin
                        a_q       <= operand_A_i;
                        b_q       <= operand_B_i;
                        partial_q <= '0;
                        carry_q   <= 1'b0;
                        low_q     <= '0;
                        cnt_q     <= '0;
                        ready_q   <= 1'b0;
                        state_q   <= MULTIPLY;
                    end
                end
                MULTIPLY: begin
                    partial_q <= stage_partial;
                    carry_q   <= stage_carry;
                    b_q       <= b_q >> P;
                    low_q     <= low_next;
                    if (cnt_q == LAST) begin
                        // Captured separately so result_o holds
                        // while the next operation runs.
                        result_q <= {stage_carry, stage_partial,
                                     low_next};
                        valid_q  <= 1'b1;
                        state_q  <= DONE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                DONE: begin
                    if (ready_i) begin
                        valid_q <= 1'b0;
                        ready_q <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign ready_o  = ready_q;
    assign valid_o  = valid_q;
    assign result_o = result_q;

endmodule

// File: tb/tb_sequential_array_multiplier.sv
// tb_sequential_array_multiplier: directed and random checks of the
// iterative multiplier at W=8/P=4, W=16/P=4 and W=32/P=8.
module tb_sequential_array_multiplier;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic [7:0]  a8, b8;
    logic        v8, ro8, vo8, ri8;
    logic [15:0] res8;

    logic [15:0] a16, b16;
    logic        v16, ro16, vo16, ri16;
    logic [31:0] res16;

    logic [31:0] a32, b32;
    logic        v32, ro32, vo32, ri32;
    logic [63:0] res32;

    int checks = 0;
    int errors = 0;

    sequential_array_multiplier #(
        .DATA_WIDTH(8), .PRODUCT_PER_STAGE(4)
    ) u_dut8 (
        .clk_i(clk), .rst_i(rst),
        .operand_A_i(a8), .operand_B_i(b8),
        .valid_i(v8), .ready_o(ro8),
        .result_o(res8), .valid_o(vo8), .ready_i(ri8)
    );

    sequential_array_multiplier #(
        .DATA_WIDTH(16), .PRODUCT_PER_STAGE(4)
    ) u_dut16 (
        .clk_i(clk), .rst_i(rst),
        .operand_A_i(a16), .operand_B_i(b16),
        .valid_i(v16), .ready_o(ro16),
        .result_o(res16), .valid_o(vo16), .ready_i(ri16)
    );

    sequential_array_multiplier #(
        .DATA_WIDTH(32), .PRODUCT_PER_STAGE(8)
    ) u_dut32 (
        .clk_i(clk), .rst_i(rst),
        .operand_A_i(a32), .operand_B_i(b32),
        .valid_i(v32), .ready_o(ro32),
        .result_o(res32), .valid_o(vo32), .ready_i(ri32)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if (ro8 !== 1'b1 || vo8 !== 1'b0 || res8 !== 16'h0000) begin
            errors++;
            $display("FAIL reset_hold ready=%b valid=%b res=%h want 1 0 0000",
                     ro8, vo8, res8);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (ro8 !== 1'b1 || vo8 !== 1'b0 || res8 !== 16'h0000) begin
            errors++;
            $display("FAIL reset_release ready=%b valid=%b res=%h want 1 0 0000",
                     ro8, vo8, res8);
        end
    endtask

    localparam logic [7:0]  VA[4] = '{8'hFF, 8'h0D, 8'h00, 8'h80};
    localparam logic [7:0]  VB[4] = '{8'hFF, 8'h0B, 8'hA5, 8'h02};
    localparam logic [15:0] VP[4] = '{16'hFE01, 16'h008F, 16'h0000, 16'h0100};

    task automatic test_basic();
        ri8 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a8 = VA[i];
            b8 = VB[i];
            v8 = 1'b1;
            tick();
            v8 = 1'b0;
            checks++;
            if (ro8 !== 1'b0 || vo8 !== 1'b0) begin
                errors++;
                $display("FAIL basic%0d_busy ready=%b valid=%b want 0 0",
                         i, ro8, vo8);
            end
            tick();
            checks++;
            if (vo8 !== 1'b0) begin
                errors++;
                $display("FAIL basic%0d_early valid=%b want 0", i, vo8);
            end
            tick();
            checks++;
            if (vo8 !== 1'b1 || res8 !== VP[i]) begin
                errors++;
                $display("FAIL basic%0d_result valid=%b res=%h want 1 %h",
                         i, vo8, res8, VP[i]);
            end
            tick();
            checks++;
            if (vo8 !== 1'b0 || ro8 !== 1'b1 || res8 !== VP[i]) begin
                errors++;
                $display("FAIL basic%0d_after valid=%b ready=%b res=%h want 0 1 %h",
                         i, vo8, ro8, res8, VP[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        ri8 = 1'b0;
        a8 = 8'h12;
        b8 = 8'h34;
        v8 = 1'b1;
        tick();
        v8 = 1'b0;
        tick();
        tick();
        for (int i = 0; i < 5; i++) begin
            a8 = 8'hFF;
            b8 = 8'hFF;
            v8 = i[0];
            tick();
            checks++;
            if (vo8 !== 1'b1 || res8 !== 16'h03A8 || ro8 !== 1'b0) begin
                errors++;
                $display("FAIL stall%0d valid=%b res=%h ready=%b want 1 03a8 0",
                         i, vo8, res8, ro8);
            end
        end
        v8 = 1'b0;
        ri8 = 1'b1;
        tick();
        checks++;
        if (vo8 !== 1'b0 || ro8 !== 1'b1) begin
            errors++;
            $display("FAIL stall_release valid=%b ready=%b want 0 1",
                     vo8, ro8);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (vo8 !== 1'b0 || ro8 !== 1'b1) begin
                errors++;
                $display("FAIL stall_ghost%0d valid=%b ready=%b want 0 1",
                         i, vo8, ro8);
            end
        end
    endtask

    task automatic test_back_to_back();
        int cyc;
        int n_acc;
        int n_res;
        int acc_cyc[2];
        logic [15:0] want[2];
        bit acc;
        want[0] = 16'h003F;
        want[1] = 16'h0E10;
        cyc = 0;
        n_acc = 0;
        n_res = 0;
        ri8 = 1'b1;
        a8 = 8'h07;
        b8 = 8'h09;
        v8 = 1'b1;
        for (int t = 0; t < 16; t++) begin
            acc = v8 && ro8;
            tick();
            cyc++;
            if (acc && n_acc < 2) begin
                acc_cyc[n_acc] = cyc;
                n_acc++;
                if (n_acc == 1) begin
                    a8 = 8'hF0;
                    b8 = 8'h0F;
                end else begin
                    v8 = 1'b0;
                end
            end
            if (vo8 === 1'b1 && n_res < 2) begin
                checks++;
                if (res8 !== want[n_res]) begin
                    errors++;
                    $display("FAIL b2b_result%0d res=%h want %h",
                             n_res, res8, want[n_res]);
                end
                n_res++;
            end
        end
        v8 = 1'b0;
        checks++;
        if (n_acc != 2 || n_res != 2) begin
            errors++;
            $display("FAIL b2b_count accepts=%0d results=%0d want 2 2",
                     n_acc, n_res);
        end else begin
            checks++;
            if (acc_cyc[1] - acc_cyc[0] != 4) begin
                errors++;
                $display("FAIL b2b_interval got=%0d want 4",
                         acc_cyc[1] - acc_cyc[0]);
            end
        end
    endtask

    task automatic test_reset_mid();
        ri8 = 1'b1;
        a8 = 8'h55;
        b8 = 8'h55;
        v8 = 1'b1;
        tick();
        v8 = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (ro8 !== 1'b1 || vo8 !== 1'b0 || res8 !== 16'h0000) begin
            errors++;
            $display("FAIL rstmid_state ready=%b valid=%b res=%h want 1 0 0000",
                     ro8, vo8, res8);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (vo8 !== 1'b0) begin
                errors++;
                $display("FAIL rstmid_quiet%0d valid=%b want 0", i, vo8);
            end
        end
        a8 = 8'h03;
        b8 = 8'h05;
        v8 = 1'b1;
        tick();
        v8 = 1'b0;
        tick();
        tick();
        checks++;
        if (vo8 !== 1'b1 || res8 !== 16'h000F) begin
            errors++;
            $display("FAIL rstmid_new valid=%b res=%h want 1 000f",
                     vo8, res8);
        end
        tick();
    endtask

    task automatic test_random_16();
        logic [15:0] x, y;
        logic [31:0] want;
        bit got;
        bit r;
        for (int n = 0; n < 1000; n++) begin
            x = 16'($urandom);
            y = 16'($urandom);
            if (n == 0) begin
                x = 16'hFFFF;
                y = 16'hFFFF;
            end
            want = 32'(x) * 32'(y);
            checks++;
            if (ro16 !== 1'b1) begin
                errors++;
                $display("FAIL rand16_ready n=%0d got=%b want 1", n, ro16);
            end
            a16 = x;
            b16 = y;
            v16 = 1'b1;
            tick();
            v16 = 1'b0;
            got = 1'b0;
            for (int t = 0; t < 40 && !got; t++) begin
                if (vo16 === 1'b1) begin
                    checks++;
                    if (res16 !== want) begin
                        errors++;
                        $display("FAIL rand16 n=%0d %h*%h res=%h want %h",
                                 n, x, y, res16, want);
                    end
                    r = 1'($urandom_range(0, 1));
                    ri16 = r;
                    tick();
                    got = r;
                end else begin
                    tick();
                end
            end
            ri16 = 1'b0;
            checks++;
            if (!got) begin
                errors++;
                $display("FAIL rand16_timeout n=%0d valid=%b want 1", n, vo16);
            end
        end
    endtask

    task automatic test_random_32();
        logic [31:0] x, y;
        logic [63:0] want;
        bit got;
        bit r;
        for (int n = 0; n < 1000; n++) begin
            x = $urandom;
            y = $urandom;
            if (n == 0) begin
                x = 32'hFFFF_FFFF;
                y = 32'hFFFF_FFFF;
            end
            want = 64'(x) * 64'(y);
            checks++;
            if (ro32 !== 1'b1) begin
                errors++;
                $display("FAIL rand32_ready n=%0d got=%b want 1", n, ro32);
            end
            a32 = x;
            b32 = y;
            v32 = 1'b1;
            tick();
            v32 = 1'b0;
            got = 1'b0;
            for (int t = 0; t < 40 && !got; t++) begin
                if (vo32 === 1'b1) begin
                    checks++;
                    if (res32 !== want) begin
                        errors++;
                        $display("FAIL rand32 n=%0d %h*%h res=%h want %h",
                                 n, x, y, res32, want);
                    end
                    r = 1'($urandom_range(0, 1));
                    ri32 = r;
                    tick();
                    got = r;
                end else begin
                    tick();
                end
            end
            ri32 = 1'b0;
            checks++;
            if (!got) begin
                errors++;
                $display("FAIL rand32_timeout n=%0d valid=%b want 1", n, vo32);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        a8 = '0;  b8 = '0;  v8 = 1'b0;  ri8 = 1'b0;
        a16 = '0; b16 = '0; v16 = 1'b0; ri16 = 1'b0;
        a32 = '0; b32 = '0; v32 = 1'b0; ri32 = 1'b0;
        test_reset();
        test_basic();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_random_16();
        test_random_32();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
